piso_shift_reg_async: RTL and testbench
=======================================

// Module: piso_shift_reg_async
// PURPOSE
//  Parallel-in, serial-out transmitter. Serialises an N-bit word held by a
//  parallel register onto a 1-bit stream, LSB first.
//  Parallel side uses a valid/ready load handshake; serial side uses
//  valid/ready per bit. Sits between a parallel data register and any
//  bit-serial consumer.
// PARAMETERS
//  N  4  data word width in bits; legal N >= 2
// PORTS
//  clk           in   1  clock, all state updates on rising edge
//  reset_ni      in   1  asynchronous, active-low reset
//  load_valid_i  in   1  d_i holds a word to send
//  load_ready_o  out  1  block can accept a word this cycle
//  d_i           in   N  parallel word
//  ser_o         out  1  current serial bit
//  ser_valid_o   out  1  ser_o is valid
//  ser_ready_i   in   1  consumer accepts ser_o this cycle
//  busy_o        out  1  a word is being shifted out
//  done_o        out  1  one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: reset_ni=0 clears all state immediately, with no clock edge needed.
//   Reset values: state=IDLE, shreg=0, cnt=0, ser_o=0, ser_valid_o=0,
//   busy_o=0, done_o=0, load_ready_o=1.
//  Reset mid-shift aborts the word. No done_o is produced for it.
//  FSM states: IDLE, SHIFT.
//  IDLE:
//   load_ready_o=1, ser_valid_o=0, busy_o=0.
//   When load_valid_i=1: shreg<=d_i, cnt<=0, go to SHIFT on the next edge.
//   Load latency: first bit is valid on ser_o 1 cycle after the load.
//  SHIFT:
//   load_ready_o=0, ser_valid_o=1, busy_o=1, ser_o=shreg[0].
//   load_valid_i is ignored; d_i is not sampled.
//   Beat accepted when ser_valid_o & ser_ready_i: shreg<=shreg>>1, cnt<=cnt+1.
//   Without acceptance, shreg, cnt and ser_o hold; the bit is never dropped.
//   On acceptance of the last beat (cnt==BEATS-1): go to IDLE, done_o=1
//   for exactly the next cycle.
//  BEATS=N, or N+1 with the parity option.
//  Throughput:
//   One bubble cycle between words (IDLE is revisited).
//   ser_ready_i held at 1 gives one word per BEATS+1 cycles.
//  cnt width is $clog2(N+2); no wrap within a word.
//  ser_o=0 whenever ser_valid_o=0.
// CONFIGURATION
//  PISO_PARITY_EN defined:
//   - One extra beat follows bit N-1: the even-parity bit ^d_i, captured at load.
//   - That bit is stored in a parity flop; done_o follows acceptance of the parity beat.
//  PISO_PARITY_EN undefined:
//   - Exactly N beats; no parity flop.
// TESTING
//  1 Reset with reset_ni=0, no clk edge.
//    -> load_ready_o=1, ser_valid_o=0, busy_o=0, done_o=0, immediately.
//  2 Load d_i=4'b1011, ser_ready_i=1 constantly.
//    -> ser_o=1,1,0,1 on 4 consecutive cycles, done_o pulse next cycle,
//       load_ready_o=1 again.
//  3 Load 4'b0110; drop ser_ready_i for 3 cycles during the 2nd beat.
//    -> ser_o stays 1 and ser_valid_o stays 1 while stalled.
//    -> Stream is 0,1,1,0 total; done_o exactly once.
//  4 While busy, drive load_valid_i=1 with d_i=4'b1111.
//    -> Ignored; the current word 4'b1001 completes as 1,0,0,1.
//  5 Async reset_ni pulse after the 2nd beat of 4'b1100.
//    -> Outputs return to reset values at once; no done_o.
//    -> The next load 4'b0011 sends 1,1,0,0.
//  6 With PISO_PARITY_EN, load 4'b1011.
//    -> Beats 1,1,0,1,1 (parity=1), then done_o.
//    -> 4'b1001 gives parity beat 0.

Source files
------------

// File: rtl/piso_shift_reg_async.sv
// Parallel-in serial-out transmitter: loads an N-bit word and sends it LSB first, one bit per accepted beat.
// Latency: the first bit is valid one cycle after the load; done_o pulses the cycle after the last beat is accepted.
// Backpressure: a low ser_ready_i holds the current bit, count and shift state; load_ready_o stays low while a word is in flight.
//
// Ports:
//   clk, reset_ni               clock (rising edge) and asynchronous active-low reset
//   load_valid_i/load_ready_o   parallel load handshake, d_i is the word to send
//   ser_o/ser_valid_o/ser_ready_i  serial bit stream with per-bit handshake
//   busy_o                      a word is being shifted out
//   done_o                      one-cycle pulse after the final beat is accepted
//
// Build option: define PISO_PARITY_EN to append an even-parity beat (^d_i)
// after bit N-1. Without it exactly N beats are sent.

module piso_shift_reg_async #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_ni,
  input  logic         load_valid_i,
  output logic         load_ready_o,
  input  logic [N-1:0] d_i,
  output logic         ser_o,
  output logic         ser_valid_o,
  input  logic         ser_ready_i,
  output logic         busy_o,
  output logic         done_o
);

`ifdef PISO_PARITY_EN
  localparam int BEATS = N + 1;
`else
  localparam int BEATS = N;
`endif
  // Wide enough to hold N+1 so the count never wraps inside a word.
  localparam int CW = $clog2(N + 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ser_valid_q, ser_valid_d;
  logic            busy_q, busy_d;
  logic            load_ready_q, load_ready_d;
  logic            done_q, done_d;
`ifdef PISO_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic            beat_acc;
  logic            last_beat;
  logic            ser_bit;

  assign beat_acc  = ser_valid_q & ser_ready_i;
  assign last_beat = (cnt_q == CW'(BEATS - 1));

`ifdef PISO_PARITY_EN
  // Once all N data bits have gone, the parity flop supplies the extra beat.
  assign ser_bit = (cnt_q == CW'(N)) ? parity_q : shreg_q[0];
`else
  assign ser_bit = shreg_q[0];
`endif

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    ser_valid_d  = ser_valid_q;
    busy_d       = busy_q;
    load_ready_d = load_ready_q;
    done_d       = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d     = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (load_valid_i) begin
          state_d      = SHIFT;
          shreg_d      = d_i;
          cnt_d        = '0;
          ser_valid_d  = 1'b1;
          busy_d       = 1'b1;
          load_ready_d = 1'b0;
`ifdef PISO_PARITY_EN
          parity_d     = ^d_i;
`endif
        end
      end
      SHIFT: begin
        // Without acceptance every piece of state holds, so no bit is lost.
        if (beat_acc) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (last_beat) begin
            state_d      = IDLE;
            ser_valid_d  = 1'b0;
            busy_d       = 1'b0;
            load_ready_d = 1'b1;
            done_d       = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ser_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
      done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ser_valid_q  <= ser_valid_d;
      busy_q       <= busy_d;
      load_ready_q <= load_ready_d;
      done_q       <= done_d;
`ifdef PISO_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Serial bit is forced low whenever no beat is being offered.
  assign ser_o        = ser_valid_q & ser_bit;
  assign ser_valid_o  = ser_valid_q;
  assign busy_o       = busy_q;
  assign load_ready_o = load_ready_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_piso_shift_reg_async.sv
// Testbench for piso_shift_reg_async with N=4: directed scenarios with hand-computed streams.
// Latency: not applicable (bench).
// Backpressure: ser_ready_i is driven by the scenarios to stall the serial side.

module tb_piso_shift_reg_async;

  logic       clk;
  logic       reset_ni;
  logic       load_valid_i;
  logic       load_ready_o;
  logic [3:0] d_i;
  logic       ser_o;
  logic       ser_valid_o;
  logic       ser_ready_i;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

`ifdef PISO_PARITY_EN
  localparam int BEATS = 5;
`else
  localparam int BEATS = 4;
`endif

  piso_shift_reg_async #(.N(4)) dut (
    .clk          (clk),
    .reset_ni     (reset_ni),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .d_i          (d_i),
    .ser_o        (ser_o),
    .ser_valid_o  (ser_valid_o),
    .ser_ready_i  (ser_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Called at a falling edge; one-cycle load pulse, returns at the falling
  // edge where the first beat is presented.
  task automatic load_word(input logic [3:0] w);
    load_valid_i = 1'b1;
    d_i          = w;
    @(negedge clk);
    load_valid_i = 1'b0;
    d_i          = 4'b0000;
  endtask

  // Records accepted beats (bit i = beat i) and done pulses until two cycles
  // after the first done, or a cycle budget runs out.
  task automatic collect(output logic [7:0] bits, output int nb, output int ndone);
    int done_at;
    bits    = '0;
    nb      = 0;
    ndone   = 0;
    done_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (done_o === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (ser_valid_o === 1'b1 && ser_ready_i === 1'b1) begin
        if (nb < 8) bits[nb] = ser_o;
        nb++;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_ni     = 1'b1;
    load_valid_i = 1'b0;
    d_i          = 4'b0000;
    ser_ready_i  = 1'b0;
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if (load_ready_o !== 1'b1 || ser_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || ser_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_clk: got rdy=%b vld=%b busy=%b done=%b ser=%b, expected 1 0 0 0 0",
               load_ready_o, ser_valid_o, busy_o, done_o, ser_o);
    end
    @(negedge clk);
    @(negedge clk);
    reset_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [3:0] e;
    e = 4'b1011;
    ser_ready_i = 1'b1;
    checks++;
    if (load_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_before: got %b expected 1", load_ready_o);
    end
    load_word(e);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ser_valid_o !== 1'b1 || ser_o !== e[i] || done_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL basic_beat%0d: got vld=%b ser=%b done=%b busy=%b, expected 1 %b 0 1",
                 i, ser_valid_o, ser_o, done_o, busy_o, e[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done_o !== 1'b1 || load_ready_o !== 1'b1 || ser_valid_o !== 1'b0 || ser_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b rdy=%b vld=%b ser=%b, expected 1 1 0 0",
               done_o, load_ready_o, ser_valid_o, ser_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_width: got %b expected 0", done_o);
    end
  endtask

  task automatic test_stall;
    logic [7:0] bits;
    logic [3:0] full;
    logic       first;
    int nb, nd;
    ser_ready_i = 1'b1;
    load_word(4'b0110);
    first = ser_o;
    @(negedge clk);
    ser_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ser_valid_o !== 1'b1 || ser_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: got vld=%b ser=%b, expected 1 1", k, ser_valid_o, ser_o);
      end
      @(negedge clk);
    end
    ser_ready_i = 1'b1;
    collect(bits, nb, nd);
    full = {bits[2:0], first};
    checks++;
    if (full !== 4'b0110 || nb != 3 || nd != 1) begin
      errors++;
      $display("FAIL stall_stream: got bits=%b beats=%0d dones=%0d, expected 0110 3 1", full, nb, nd);
    end
  endtask

  task automatic test_ignore_load;
    logic [7:0] bits;
    int nb, nd;
    ser_ready_i = 1'b0;
    load_word(4'b1001);
    load_valid_i = 1'b1;
    d_i          = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (load_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL ignore_ready%0d: got rdy=%b busy=%b, expected 0 1", k, load_ready_o, busy_o);
      end
      @(negedge clk);
    end
    load_valid_i = 1'b0;
    d_i          = 4'b0000;
    ser_ready_i  = 1'b1;
    collect(bits, nb, nd);
    checks++;
    if (bits[3:0] !== 4'b1001 || nb != BEATS || nd != 1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ignore_stream: got bits=%b beats=%0d dones=%0d busy=%b, expected 1001 %0d 1 0",
               bits[3:0], nb, nd, busy_o, BEATS);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] bits;
    int nb, nd;
    ser_ready_i = 1'b1;
    load_word(4'b1100);
    @(negedge clk);
    @(negedge clk);
    #2 reset_ni = 1'b0;
    #1;
    checks++;
    if (load_ready_o !== 1'b1 || ser_valid_o !== 1'b0 || busy_o !== 1'b0 ||
        done_o !== 1'b0 || ser_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b done=%b ser=%b, expected 1 0 0 0 0",
               load_ready_o, ser_valid_o, busy_o, done_o, ser_o);
    end
    #1 reset_ni = 1'b1;
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: got %0d cycles with done/busy, expected 0", nd);
    end
    load_word(4'b0011);
    collect(bits, nb, nd);
    checks++;
    if (bits[3:0] !== 4'b0011 || nb != BEATS || nd != 1) begin
      errors++;
      $display("FAIL reset_mid_next: got bits=%b beats=%0d dones=%0d, expected 0011 %0d 1",
               bits[3:0], nb, nd, BEATS);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity;
    logic [7:0] bits;
    int nb, nd;
    ser_ready_i = 1'b1;
    load_word(4'b1011);
    collect(bits, nb, nd);
    checks++;
    if (bits[4:0] !== 5'b11011 || nb != 5 || nd != 1) begin
      errors++;
      $display("FAIL parity_1011: got bits=%b beats=%0d dones=%0d, expected 11011 5 1", bits[4:0], nb, nd);
    end
    load_word(4'b1001);
    collect(bits, nb, nd);
    checks++;
    if (bits[4:0] !== 5'b01001 || nb != 5 || nd != 1) begin
      errors++;
      $display("FAIL parity_1001: got bits=%b beats=%0d dones=%0d, expected 01001 5 1", bits[4:0], nb, nd);
    end
  endtask
`endif

  task automatic test_back_to_back;
    int d1, d2;
    logic rdy_at_done;
    d1 = -1;
    d2 = -1;
    rdy_at_done = 1'b0;
    ser_ready_i  = 1'b1;
    load_valid_i = 1'b1;
    d_i          = 4'b0101;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        if (d1 < 0) begin
          d1 = c;
          rdy_at_done = load_ready_o;
        end else begin
          d2 = c;
          load_valid_i = 1'b0;
          break;
        end
      end
    end
    load_valid_i = 1'b0;
    checks++;
    if (d1 < 0 || d2 < 0 || (d2 - d1) != BEATS + 1 || rdy_at_done !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: got done gap=%0d ready=%b, expected gap %0d ready 1",
               d2 - d1, rdy_at_done, BEATS + 1);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ser_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_idle: got busy=%b vld=%b, expected 0 0", busy_o, ser_valid_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_ignore_load;
    test_reset_mid;
`ifdef PISO_PARITY_EN
    test_parity;
`endif
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
